decode_scan: RTL

Parametrised, registered W-to-2^W one-hot decoder with two operating modes: direct decode of a select input, and autonomous scan that steps the active output through every channel with a programmable dwell time. Generalises the team's combinational 2-to-4 enable decoder into a clocked block for driving multiplexed loads such as digit enables, row strobes and bank selects. It sits between control logic and the strobed resource.

---
 rtl/decode_scan.sv | 120 ++++++++++++
 1 files changed

// File: rtl/decode_scan.sv
// rtl/decode_scan.sv - registered W-to-2^W one-hot decoder with direct and dwell-timed scan modes
//
// Purpose:
//   Drives one of N = 2^W channel strobes. In direct mode the active channel
//   follows sel one cycle later. In scan mode the active channel starts at sel
//   and advances through every channel, holding each for DWELL cycles, and
//   pulses wrap when the index rolls over from N-1 to 0.
//
// Parameters:
//   W      select width (>= 1); N = 2^W outputs
//   DWELL  cycles per channel in scan mode (>= 1)
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   en     in   1  block enable; 0 forces all outputs inactive
//   mode   in   1  0 = direct decode, 1 = scan
//   sel    in   W  direct channel index / scan start index
//   out    out  N  registered channel strobe
//   idx    out  W  registered channel index
//   wrap   out  1  one-cycle pulse on scan rollover N-1 -> 0
//
// Configuration:
//   DECODE_SCAN_ACTIVE_LOW_EN  when defined, out is one-cold (inactive = 1,
//                              active channel = 0); idle/reset value all-ones.

module decode_scan #(
    parameter int W     = 2,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [W-1:0]        sel,
    output logic [(1<<W)-1:0]   out,
    output logic [W-1:0]        idx,
    output logic                wrap
);

    localparam int N  = 1 << W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

`ifdef DECODE_SCAN_ACTIVE_LOW_EN
    localparam logic [N-1:0] OUT_OFF = {N{1'b1}};
`else
    localparam logic [N-1:0] OUT_OFF = {N{1'b0}};
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [W-1:0]  IDX_LAST = W'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  out_q, out_d;
    logic          wrap_q, wrap_d;

    // One-hot of the index, XORed with the idle pattern so the same
    // expression yields one-cold when the active-low build is selected.
    function automatic logic [N-1:0] strobe(input logic [W-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r ^ OUT_OFF;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        out_d   = OUT_OFF;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = sel;
            out_d   = strobe(sel);
        end else begin
            state_d = ST_SCAN;
            if (state_q != ST_SCAN) begin
                // Entry always reloads from sel and restarts the dwell.
                idx_d = sel;
            end else if (cnt_q == CNT_LAST) begin
                idx_d  = idx_q + W'(1);
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            out_d = strobe(idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= OUT_OFF;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
